cgra_periph_regs_param: RTL

Parametrised CGRA control/status register block with a native register bus. It holds per-slot kernel IDs and per-column I/O pointers, and tracks column busy status. It provides per-column active/stall performance counters and raises a maskable column-end interrupt. It sits between the host register bus and the CGRA context/column controllers, for any column or slot count.

---
 rtl/cgra_periph_regs_if.sv | 26 ++
 rtl/cgra_periph_regs_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_periph_regs_if.sv
// Register-bus interface for cgra_periph_regs_param.
// The master issues one request at a time (reg_valid_i held until
// reg_ready_o); the slave answers with a single-cycle reg_ready_o strobe
// carrying reg_rdata_o / reg_error_o. Signal names keep the block's original
// port names so existing wiring maps one to one.
interface cgra_periph_regs_param_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              reg_valid_i;
  logic              reg_write_i;
  logic [ADDR_W-1:0] reg_addr_i;
  logic [31:0]       reg_wdata_i;
  logic              reg_ready_o;
  logic [31:0]       reg_rdata_o;
  logic              reg_error_o;

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o
  );

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
    output reg_ready_o, reg_rdata_o, reg_error_o
  );
endinterface

// File: rtl/cgra_periph_regs_param.sv
// cgra_periph_regs_param: CGRA control/status register block.
//
// Holds per-slot kernel IDs and per-column I/O pointers, tracks column busy
// status, keeps per-column active/stall performance counters plus a kernel
// total, and raises a maskable column-end interrupt.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   bus             register bus (slave modport of cgra_periph_regs_param_if)
//   acc_req_i       columns requested by the pending kernel
//   acc_ack_i       request accepted; ack_slot_i names the slot consumed
//   acc_end_i       per-column end pulse
//   col_stall_i     per-column stall
//   col_status_o    per-column busy
//   core_ker_id_o   packed kernel IDs, slot s at [s*KER_ID_W +: KER_ID_W]
//   core_rd_ptr_o   packed input pointers, index s*MAX_COL_REQ+c
//   core_wr_ptr_o   packed output pointers, same indexing
//   irq_o           level interrupt (irq_en & any end flag)
//
// Word map (word = addr>>2): 0 CTRL, 1 STATUS, 2 IRQ_STATUS (W1C),
// 3 TOTAL_KERNELS, 4+2c ACTIVE[c], 5+2c STALL[c], then per slot s at
// B=4+2*N_COL+s*(1+2*MAX_COL_REQ): B ker_id, B+1+2c ptr_in[c], B+2+2c ptr_out[c].
//
// Build option: define CGRA_PERF_CNT_SAT_EN to make TOTAL/ACTIVE/STALL
// saturate at all-ones instead of wrapping.
module cgra_periph_regs_param #(
  parameter int unsigned N_COL       = 4,
  parameter int unsigned N_SLOTS     = 2,
  parameter int unsigned MAX_COL_REQ = 4,
  parameter int unsigned DP_WIDTH    = 32,
  parameter int unsigned KER_ID_W    = 6,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ADDR_W      = 10,
  localparam int unsigned SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  cgra_periph_regs_param_if.slave                bus,
  input  logic [N_COL-1:0]                       acc_req_i,
  input  logic                                   acc_ack_i,
  input  logic [SLOT_W-1:0]                      ack_slot_i,
  input  logic [N_COL-1:0]                       acc_end_i,
  input  logic [N_COL-1:0]                       col_stall_i,
  output logic [N_COL-1:0]                       col_status_o,
  output logic [N_SLOTS*KER_ID_W-1:0]            core_ker_id_o,
  output logic [N_SLOTS*MAX_COL_REQ*DP_WIDTH-1:0] core_rd_ptr_o,
  output logic [N_SLOTS*MAX_COL_REQ*DP_WIDTH-1:0] core_wr_ptr_o,
  output logic                                   irq_o
);

  localparam int unsigned W_CTRL      = 0;
  localparam int unsigned W_STATUS    = 1;
  localparam int unsigned W_IRQ       = 2;
  localparam int unsigned W_TOTAL     = 3;
  localparam int unsigned ACT_BASE    = 4;
  localparam int unsigned SLOT_BASE   = 4 + 2 * N_COL;
  localparam int unsigned SLOT_STRIDE = 1 + 2 * MAX_COL_REQ;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } bus_state_e;

  bus_state_e state_q, state_d;

  logic                cnt_en_q, cnt_reset_q, irq_en_q, irq_q;
  logic [N_COL-1:0]    col_status_q, irq_status_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    act_q   [N_COL];
  logic [CNT_W-1:0]    stall_q [N_COL];
  logic [KER_ID_W-1:0] ker_q   [N_SLOTS];
  logic [DP_WIDTH-1:0] pin_q   [N_SLOTS][MAX_COL_REQ];
  logic [DP_WIDTH-1:0] pout_q  [N_SLOTS][MAX_COL_REQ];
  logic [31:0]         rdata_q;
  logic                error_q;

  logic                accept, wr_en, dec_hit, dec_err;
  logic [ADDR_W-3:0]   widx;
  int unsigned         w;
  logic [31:0]         rd_data;
  logic [N_COL-1:0]    w1c_mask, irq_status_d, col_status_d;
  logic                irq_en_d;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^bus.reg_addr_i[1:0];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef CGRA_PERF_CNT_SAT_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // Bus FSM: the access is performed on the edge that samples reg_valid_i,
  // and the response strobe follows in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.reg_valid_i) begin
          accept  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode and read mux.
  always_comb begin
    widx    = bus.reg_addr_i[ADDR_W-1:2];
    w       = 32'(widx);
    rd_data = '0;
    dec_hit = 1'b0;
    if (w == W_CTRL) begin
      dec_hit = 1'b1;
      rd_data = {29'd0, irq_en_q, cnt_reset_q, cnt_en_q};
    end
    if (w == W_STATUS) begin
      dec_hit = 1'b1;
      rd_data = 32'(col_status_q);
    end
    if (w == W_IRQ) begin
      dec_hit = 1'b1;
      rd_data = 32'(irq_status_q);
    end
    if (w == W_TOTAL) begin
      dec_hit = 1'b1;
      rd_data = 32'(total_q);
    end
    for (int unsigned c = 0; c < N_COL; c++) begin
      if (w == ACT_BASE + 2 * c) begin
        dec_hit = 1'b1;
        rd_data = 32'(act_q[c]);
      end
      if (w == ACT_BASE + 2 * c + 1) begin
        dec_hit = 1'b1;
        rd_data = 32'(stall_q[c]);
      end
    end
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      if (w == SLOT_BASE + s * SLOT_STRIDE) begin
        dec_hit = 1'b1;
        rd_data = 32'(ker_q[s]);
      end
      for (int unsigned c = 0; c < MAX_COL_REQ; c++) begin
        if (w == SLOT_BASE + s * SLOT_STRIDE + 1 + 2 * c) begin
          dec_hit = 1'b1;
          rd_data = 32'(pin_q[s][c]);
        end
        if (w == SLOT_BASE + s * SLOT_STRIDE + 2 + 2 * c) begin
          dec_hit = 1'b1;
          rd_data = 32'(pout_q[s][c]);
        end
      end
    end
    dec_err = !dec_hit || (bus.reg_write_i && (w == W_STATUS));
  end

  assign wr_en = accept && bus.reg_write_i && !dec_err;

  always_comb begin
    w1c_mask     = (wr_en && (w == W_IRQ)) ? bus.reg_wdata_i[N_COL-1:0] : '0;
    irq_status_d = (irq_status_q & ~w1c_mask) | acc_end_i;
    irq_en_d     = (wr_en && (w == W_CTRL)) ? bus.reg_wdata_i[2] : irq_en_q;
    col_status_d = (col_status_q & ~acc_end_i) | (acc_ack_i ? acc_req_i : '0);
  end

  // Bus response, control, status and interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q      <= '0;
      error_q      <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_reset_q  <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      col_status_q <= '0;
      irq_status_q <= '0;
    end else begin
      if (accept) begin
        error_q <= dec_err;
        rdata_q <= (dec_err || bus.reg_write_i) ? '0 : rd_data;
      end
      if (wr_en && (w == W_CTRL)) begin
        cnt_en_q    <= bus.reg_wdata_i[0];
        cnt_reset_q <= bus.reg_wdata_i[1];
      end else begin
        cnt_reset_q <= 1'b0;
      end
      irq_en_q     <= irq_en_d;
      col_status_q <= col_status_d;
      irq_status_q <= irq_status_d;
      // Built from next-state values so irq_o follows the end pulse by one cycle.
      irq_q        <= irq_en_d && (|irq_status_d);
    end
  end

  // Performance counters: cnt_reset, then SW write, then increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= '0;
      for (int unsigned c = 0; c < N_COL; c++) begin
        act_q[c]   <= '0;
        stall_q[c] <= '0;
      end
    end else begin
      if (cnt_reset_q)
        total_q <= '0;
      else if (wr_en && (w == W_TOTAL))
        total_q <= bus.reg_wdata_i[CNT_W-1:0];
      else if (cnt_en_q && acc_ack_i)
        total_q <= cnt_inc(total_q);
      for (int unsigned c = 0; c < N_COL; c++) begin
        if (cnt_reset_q)
          act_q[c] <= '0;
        else if (wr_en && (w == ACT_BASE + 2 * c))
          act_q[c] <= bus.reg_wdata_i[CNT_W-1:0];
        else if (cnt_en_q && (col_status_q[c] || acc_req_i[c]))
          act_q[c] <= cnt_inc(act_q[c]);
        if (cnt_reset_q)
          stall_q[c] <= '0;
        else if (wr_en && (w == ACT_BASE + 2 * c + 1))
          stall_q[c] <= bus.reg_wdata_i[CNT_W-1:0];
        else if (cnt_en_q && col_stall_i[c])
          stall_q[c] <= cnt_inc(stall_q[c]);
      end
    end
  end

  // Slot registers. An ack clears the consumed slot's kernel ID and beats a
  // same-cycle SW write; an out-of-range ack_slot_i matches no slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < N_SLOTS; s++) begin
        ker_q[s] <= '0;
        for (int unsigned c = 0; c < MAX_COL_REQ; c++) begin
          pin_q[s][c]  <= '0;
          pout_q[s][c] <= '0;
        end
      end
    end else begin
      for (int unsigned s = 0; s < N_SLOTS; s++) begin
        if (acc_ack_i && (32'(ack_slot_i) == s))
          ker_q[s] <= '0;
        else if (wr_en && (w == SLOT_BASE + s * SLOT_STRIDE))
          ker_q[s] <= bus.reg_wdata_i[KER_ID_W-1:0];
        for (int unsigned c = 0; c < MAX_COL_REQ; c++) begin
          if (wr_en && (w == SLOT_BASE + s * SLOT_STRIDE + 1 + 2 * c))
            pin_q[s][c] <= bus.reg_wdata_i[DP_WIDTH-1:0];
          if (wr_en && (w == SLOT_BASE + s * SLOT_STRIDE + 2 + 2 * c))
            pout_q[s][c] <= bus.reg_wdata_i[DP_WIDTH-1:0];
        end
      end
    end
  end

  // Output packing.
  always_comb begin
    core_ker_id_o = '0;
    core_rd_ptr_o = '0;
    core_wr_ptr_o = '0;
    for (int unsigned s = 0; s < N_SLOTS; s++) begin
      core_ker_id_o[s*KER_ID_W +: KER_ID_W] = ker_q[s];
      for (int unsigned c = 0; c < MAX_COL_REQ; c++) begin
        core_rd_ptr_o[(s*MAX_COL_REQ+c)*DP_WIDTH +: DP_WIDTH] = pin_q[s][c];
        core_wr_ptr_o[(s*MAX_COL_REQ+c)*DP_WIDTH +: DP_WIDTH] = pout_q[s][c];
      end
    end
  end

  assign bus.reg_ready_o = (state_q == S_RESP);
  assign bus.reg_rdata_o = rdata_q;
  assign bus.reg_error_o = error_q;
  assign col_status_o    = col_status_q;
  assign irq_o           = irq_q;

endmodule
